// File: rtl/tic_tac_toe_pkg.sv
// tic_tac_toe_pkg
//   Shared constants for the PS/2 keyboard input path of the tic-tac-toe game.
//   Holds the set-2 scan codes the game reacts to, the cursor direction
//   encodings, the receiver state enum and a scan-code to cell-index helper.
//   No ports: imported by ps2_rx_byte and tic_tac_toe_input_ps2.
package tic_tac_toe_pkg;

   // Set-2 make codes for the digit row '1'..'9'
   localparam logic [7:0] SC_1 = 8'h16;
   localparam logic [7:0] SC_2 = 8'h1E;
   localparam logic [7:0] SC_3 = 8'h26;
   localparam logic [7:0] SC_4 = 8'h25;
   localparam logic [7:0] SC_5 = 8'h2E;
   localparam logic [7:0] SC_6 = 8'h36;
   localparam logic [7:0] SC_7 = 8'h3D;
   localparam logic [7:0] SC_8 = 8'h3E;
   localparam logic [7:0] SC_9 = 8'h46;

   // Control keys and the two prefix bytes
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_ESC   = 8'h76;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;

   // Arrow keys (only meaningful after an E0 prefix)
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   // Cursor direction encodings seen by ticTacToeCore
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // Returns {hit, index}: hit is set when the code is one of the nine digit keys
   function automatic logic [4:0] map_cell(input logic [7:0] code);
      logic [4:0] result;
      result = 5'd0;
      case (code)
         SC_1: result = {1'b1, 4'd0};
         SC_2: result = {1'b1, 4'd1};
         SC_3: result = {1'b1, 4'd2};
         SC_4: result = {1'b1, 4'd3};
         SC_5: result = {1'b1, 4'd4};
         SC_6: result = {1'b1, 4'd5};
         SC_7: result = {1'b1, 4'd6};
         SC_8: result = {1'b1, 4'd7};
         SC_9: result = {1'b1, 4'd8};
         default: result = 5'd0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/tic_tac_toe_input_ps2_rx_byte.sv
// ps2_rx_byte
//   Receives device-to-host PS/2 frames (start, 8 data bits LSB first, odd
//   parity, stop) and reports each good byte with a one-cycle strobe.
//   Ports:
//     clock       in   system clock
//     reset       in   asynchronous active-high reset
//     ps2_clk     in   raw PS/2 clock (asynchronous to clock)
//     ps2_dat     in   raw PS/2 data  (asynchronous to clock)
//     rx_byte     out  last received data byte, meaningful with byte_valid
//     byte_valid  out  one-cycle pulse: a frame passed all checks
//     frame_error out  one-cycle pulse: bad start, parity, stop or timeout
module ps2_rx_byte
   import tic_tac_toe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_error
);

   localparam int             TW       = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          prev_clk;
   logic          fall;
   logic          sdat;

   rx_state_t     state, state_n;
   logic [7:0]    shift_reg, shift_n;
   logic [2:0]    bit_count, count_n;
   logic          parity_bit, parity_n;
   logic          valid_n, error_n;
   logic [TW-1:0] tmo_count;
   logic          timed_out;

   assign fall      = prev_clk & ~clk_sync[1];
   assign sdat      = dat_sync[1];
   assign timed_out = (tmo_count == TMO_LAST);
   assign rx_byte   = shift_reg;

   // Two-flop synchronizers for both PS/2 lines plus the delayed clock used
   // for falling-edge detection. Everything resets high, the idle bus level,
   // so leaving reset can never look like a clock fall.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         prev_clk <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
         prev_clk <= clk_sync[1];
      end
   end

   // Inactivity timer: restarts on every PS/2 clock fall and only advances
   // while a frame is in progress. It parks at its last value instead of
   // wrapping so a stalled frame is aborted exactly once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tmo_count <= '0;
      end else if (fall || state == RX_IDLE) begin
         tmo_count <= '0;
      end else if (!timed_out) begin
         tmo_count <= tmo_count + 1'b1;
      end
   end

   // Receiver state and datapath registers; the strobes are registered here
   // so byte_valid lands one cycle after the stop-bit fall.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= RX_IDLE;
         shift_reg   <= '0;
         bit_count   <= '0;
         parity_bit  <= 1'b0;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_n;
         shift_reg   <= shift_n;
         bit_count   <= count_n;
         parity_bit  <= parity_n;
         byte_valid  <= valid_n;
         frame_error <= error_n;
      end
   end

   // Frame sequencing. Data bits arrive LSB first, so they shift in from the
   // top. A stall anywhere inside a frame overrides the normal transition and
   // throws the partial byte away.
   always_comb begin
      state_n  = state;
      shift_n  = shift_reg;
      count_n  = bit_count;
      parity_n = parity_bit;
      valid_n  = 1'b0;
      error_n  = 1'b0;
      case (state)
         RX_IDLE: begin
            if (fall) begin
               if (!sdat) begin
                  state_n = RX_DATA;
                  count_n = 3'd0;
               end else begin
                  error_n = 1'b1;
               end
            end
         end
         RX_DATA: begin
            if (fall) begin
               shift_n = {sdat, shift_reg[7:1]};
               count_n = bit_count + 3'd1;
               if (bit_count == 3'd7) begin
                  state_n = RX_PARITY;
               end
            end
         end
         RX_PARITY: begin
            if (fall) begin
               parity_n = sdat;
               state_n  = RX_STOP;
            end
         end
         RX_STOP: begin
            if (fall) begin
               state_n = RX_IDLE;
               if (sdat && (^{shift_reg, parity_bit})) begin
                  valid_n = 1'b1;
               end else begin
                  error_n = 1'b1;
               end
            end
         end
         default: state_n = RX_IDLE;
      endcase
      if (state != RX_IDLE && !fall && timed_out) begin
         state_n = RX_IDLE;
         error_n = 1'b1;
      end
   end

endmodule

// File: rtl/tic_tac_toe_input_ps2.sv
// tic_tac_toe_input_ps2
//   Turns PS/2 set-2 keyboard traffic into one-cycle game commands for
//   ticTacToeCore; the pulses are OR-ed with the debounced button path.
//   Ports:
//     CLOCK             in   system clock (50 MHz)
//     reset             in   asynchronous active-high reset
//     PS2_CLK, PS2_DAT  in   raw PS/2 lines from the connector
//     cell_select       out  cell 0..8 for keys '1'..'9', with cell_select_valid
//     cell_select_valid out  pulse: digit key pressed
//     cursor_move       out  pulse: arrow key pressed
//     cursor_dir        out  0 up, 1 down, 2 left, 3 right, with cursor_move
//     cell_enter        out  pulse: Enter or keypad Enter pressed
//     reset_request     out  pulse: Esc pressed
//     frame_error       out  pulse: receiver rejected or abandoned a frame
module tic_tac_toe_input_ps2
   import tic_tac_toe_pkg::*;
#(
   parameter int TIMEOUT_CYCLES  = 50000,
   parameter bit SUPPRESS_REPEAT = 1'b1
) (
   input  logic       CLOCK,
   input  logic       reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DAT,
   output logic [3:0] cell_select,
   output logic       cell_select_valid,
   output logic       cursor_move,
   output logic [1:0] cursor_dir,
   output logic       cell_enter,
   output logic       reset_request,
   output logic       frame_error
);

   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       rx_error;

   logic       ext, brk;
   logic [8:0] last_make;

   logic [8:0] key;
   logic       is_prefix;
   logic       make_fire;
   logic [4:0] cell_map;
   logic       sel_valid_n, move_n, enter_n, reset_req_n;
   logic [3:0] sel_n;
   logic [1:0] dir_n;

   ps2_rx_byte #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_rx (
      .clock      (CLOCK),
      .reset      (reset),
      .ps2_clk    (PS2_CLK),
      .ps2_dat    (PS2_DAT),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_error(rx_error)
   );

   // Decode the byte just received. A make fires unless it is a typematic
   // repeat of the key still held (same extended code as the last make).
   // Keypad Enter shares the plain Enter command; keypad digits/arrows
   // without E0 are deliberately ignored.
   always_comb begin
      key         = {ext, rx_byte};
      is_prefix   = (rx_byte == SC_EXT) || (rx_byte == SC_BRK);
      make_fire   = byte_valid && !is_prefix && !brk &&
                    !(SUPPRESS_REPEAT && (key == last_make));
      cell_map    = map_cell(rx_byte);
      sel_valid_n = make_fire && !ext && cell_map[4];
      sel_n       = cell_map[4] ? cell_map[3:0] : 4'd0;
      enter_n     = make_fire && (rx_byte == SC_ENTER);
      reset_req_n = make_fire && !ext && (rx_byte == SC_ESC);
      move_n      = 1'b0;
      dir_n       = DIR_UP;
      if (make_fire && ext) begin
         case (rx_byte)
            SC_UP:    begin move_n = 1'b1; dir_n = DIR_UP;    end
            SC_DOWN:  begin move_n = 1'b1; dir_n = DIR_DOWN;  end
            SC_LEFT:  begin move_n = 1'b1; dir_n = DIR_LEFT;  end
            SC_RIGHT: begin move_n = 1'b1; dir_n = DIR_RIGHT; end
            default:  begin move_n = 1'b0; dir_n = DIR_UP;    end
         endcase
      end
   end

   // Prefix flags and held-key memory. A receive error abandons any pending
   // E0/F0 prefix but keeps the held key, since the keyboard still holds it.
   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         ext       <= 1'b0;
         brk       <= 1'b0;
         last_make <= '0;
      end else if (rx_error) begin
         ext <= 1'b0;
         brk <= 1'b0;
      end else if (byte_valid) begin
         if (rx_byte == SC_EXT) begin
            ext <= 1'b1;
         end else if (rx_byte == SC_BRK) begin
            brk <= 1'b1;
         end else begin
            ext <= 1'b0;
            brk <= 1'b0;
            if (brk) begin
               if (key == last_make) begin
                  last_make <= '0;
               end
            end else if (make_fire) begin
               last_make <= key;
            end
         end
      end
   end

   // Registered command outputs; data fields are zero whenever their strobe
   // is low so the OR with the button path stays clean.
   always_ff @(posedge CLOCK or posedge reset) begin
      if (reset) begin
         cell_select       <= 4'd0;
         cell_select_valid <= 1'b0;
         cursor_move       <= 1'b0;
         cursor_dir        <= 2'd0;
         cell_enter        <= 1'b0;
         reset_request     <= 1'b0;
         frame_error       <= 1'b0;
      end else begin
         cell_select       <= sel_valid_n ? sel_n : 4'd0;
         cell_select_valid <= sel_valid_n;
         cursor_move       <= move_n;
         cursor_dir        <= move_n ? dir_n : 2'd0;
         cell_enter        <= enter_n;
         reset_request     <= reset_req_n;
         frame_error       <= rx_error;
      end
   end

endmodule

// File: tb/tb_tic_tac_toe_input_ps2.sv
// tb_tic_tac_toe_input_ps2
//   Drives PS/2 frames into tic_tac_toe_input_ps2 and compares every output
//   on every cycle against a keyboard-level model of the command stream.
module tb_tic_tac_toe_input_ps2;

   localparam int HALF_BIT = 4;

   typedef struct packed {
      logic       sel_v;
      logic [3:0] sel;
      logic       move;
      logic [1:0] dir;
      logic       enter;
      logic       rst_req;
      logic       ferr;
   } cmd_t;

   logic       clock;
   logic       reset;
   logic       ps2_clk;
   logic       ps2_dat;
   logic [3:0] cell_select;
   logic       cell_select_valid;
   logic       cursor_move;
   logic [1:0] cursor_dir;
   logic       cell_enter;
   logic       reset_request;
   logic       frame_error;

   int   cyc;
   int   n_checks;
   int   n_errors;
   bit   checking;
   bit   ferr_dont_care;
   cmd_t sched [int];

   // Keyboard-level model state
   bit         m_ext;
   bit         m_brk;
   logic [8:0] m_last;
   int         last_stop_cyc;

   // Observed pulse statistics, written only by the compare process
   int sel_cnt, move_cnt, enter_cnt, rst_cnt, ferr_cnt, dc_ferr_cnt;
   int last_cell, last_dir, last_sel_cyc;

   cmd_t e_cmd, a_cmd;

   tic_tac_toe_input_ps2 #(
      .TIMEOUT_CYCLES (50000),
      .SUPPRESS_REPEAT(1'b1)
   ) dut (
      .CLOCK            (clock),
      .reset            (reset),
      .PS2_CLK          (ps2_clk),
      .PS2_DAT          (ps2_dat),
      .cell_select      (cell_select),
      .cell_select_valid(cell_select_valid),
      .cursor_move      (cursor_move),
      .cursor_dir       (cursor_dir),
      .cell_enter       (cell_enter),
      .reset_request    (reset_request),
      .frame_error      (frame_error)
   );

   // 50 MHz system clock
   initial clock = 1'b0;
   always #10 clock = ~clock;

   // Cycle index used to timestamp stimulus and expectations
   always @(posedge clock) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, actual, expected);
      end
   endtask

   // Model of what a keyboard byte means to the game
   task automatic model_byte(input logic [7:0] b, output cmd_t c);
      logic [7:0] digits [9];
      logic [7:0] arrows [4];
      logic [8:0] k;
      digits = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
      arrows = '{8'h75, 8'h72, 8'h6B, 8'h74};
      c = '0;
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         k = {m_ext, b};
         if (m_brk) begin
            if (k == m_last) m_last = '0;
         end else if (k != m_last) begin
            m_last = k;
            if (!m_ext) begin
               for (int i = 0; i < 9; i++)
                  if (digits[i] == b) begin c.sel_v = 1'b1; c.sel = 4'(i); end
               if (b == 8'h76) c.rst_req = 1'b1;
            end else begin
               for (int i = 0; i < 4; i++)
                  if (arrows[i] == b) begin c.move = 1'b1; c.dir = 2'(i); end
            end
            if (b == 8'h5A) c.enter = 1'b1;
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   // Send the first nbits bits of a frame; a complete frame also books the
   // expected command four sample points after the stop-bit clock fall.
   task automatic applyStimulus(input logic [7:0] d, input bit flip_par,
                                input bit stop_bit, input int nbits);
      logic [10:0] frame;
      cmd_t        c;
      frame = {stop_bit, (~^d) ^ flip_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clock);
         ps2_dat = frame[i];
         repeat (HALF_BIT) @(negedge clock);
         ps2_clk = 1'b0;
         if (i == 10) begin
            if (stop_bit && !flip_par) begin
               model_byte(d, c);
            end else begin
               m_ext = 1'b0;
               m_brk = 1'b0;
               c = '0;
               c.ferr = 1'b1;
            end
            sched[cyc + 4] = c;
            last_stop_cyc = cyc;
         end
         repeat (HALF_BIT) @(negedge clock);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Per-cycle comparison against the scheduled expectations
   always @(negedge clock) begin
      if (!reset && checking) begin
         e_cmd = sched.exists(cyc) ? sched[cyc] : cmd_t'('0);
         a_cmd.sel_v   = cell_select_valid;
         a_cmd.sel     = e_cmd.sel_v ? cell_select : 4'd0;
         a_cmd.move    = cursor_move;
         a_cmd.dir     = e_cmd.move ? cursor_dir : 2'd0;
         a_cmd.enter   = cell_enter;
         a_cmd.rst_req = reset_request;
         a_cmd.ferr    = frame_error;
         if (ferr_dont_care) begin
            a_cmd.ferr = 1'b0;
            e_cmd.ferr = 1'b0;
            if (frame_error) dc_ferr_cnt <= dc_ferr_cnt + 1;
         end else if (frame_error) begin
            ferr_cnt <= ferr_cnt + 1;
         end
         checkOutput("cycle outputs", int'(a_cmd), int'(e_cmd));
         if (cell_select_valid) begin
            sel_cnt      <= sel_cnt + 1;
            last_cell    <= int'(cell_select);
            last_sel_cyc <= cyc;
         end
         if (cursor_move) begin
            move_cnt <= move_cnt + 1;
            last_dir <= int'(cursor_dir);
         end
         if (cell_enter)    enter_cnt <= enter_cnt + 1;
         if (reset_request) rst_cnt   <= rst_cnt + 1;
      end
   end

   initial begin
      #3ms;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      n_checks = 0;   n_errors = 0;   checking = 1'b0;   ferr_dont_care = 1'b0;
      m_ext = 1'b0;   m_brk = 1'b0;   m_last = '0;
      reset = 1'b1;   ps2_clk = 1'b1; ps2_dat = 1'b1;
      idle(3);
      checkOutput("reset cell_select_valid", int'(cell_select_valid), 0);
      checkOutput("reset cell_select", int'(cell_select), 0);
      checkOutput("reset cursor_move", int'(cursor_move), 0);
      checkOutput("reset cursor_dir", int'(cursor_dir), 0);
      checkOutput("reset cell_enter", int'(cell_enter), 0);
      checkOutput("reset reset_request", int'(reset_request), 0);
      checkOutput("reset frame_error", int'(frame_error), 0);
      reset = 1'b0;
      checking = 1'b1;
      idle(5);

      $display("[TB] test 1: single digit 5");
      applyStimulus(8'h2E, 1'b0, 1'b1, 11);
      idle(10);
      checkOutput("t1 select count", sel_cnt, 1);
      checkOutput("t1 cell", last_cell, 4);
      checkOutput("t1 latency", last_sel_cyc - last_stop_cyc, 4);

      $display("[TB] test 2: right arrow make and break");
      applyStimulus(8'hE0, 1'b0, 1'b1, 11);
      applyStimulus(8'h74, 1'b0, 1'b1, 11);
      applyStimulus(8'hE0, 1'b0, 1'b1, 11);
      applyStimulus(8'hF0, 1'b0, 1'b1, 11);
      applyStimulus(8'h74, 1'b0, 1'b1, 11);
      idle(10);
      checkOutput("t2 move count", move_cnt, 1);
      checkOutput("t2 dir", last_dir, 3);

      $display("[TB] test 3: typematic repeat suppression");
      applyStimulus(8'h16, 1'b0, 1'b1, 11);
      applyStimulus(8'h16, 1'b0, 1'b1, 11);
      applyStimulus(8'h16, 1'b0, 1'b1, 11);
      applyStimulus(8'hF0, 1'b0, 1'b1, 11);
      applyStimulus(8'h16, 1'b0, 1'b1, 11);
      applyStimulus(8'h16, 1'b0, 1'b1, 11);
      idle(10);
      checkOutput("t3 select count", sel_cnt, 3);
      checkOutput("t3 cell", last_cell, 0);

      $display("[TB] test 4: parity error then good Enter");
      applyStimulus(8'h5A, 1'b1, 1'b1, 11);
      idle(10);
      checkOutput("t4 error count", ferr_cnt, 1);
      checkOutput("t4 enter before good frame", enter_cnt, 0);
      applyStimulus(8'h5A, 1'b0, 1'b1, 11);
      idle(10);
      checkOutput("t4 enter count", enter_cnt, 1);

      $display("[TB] test 5: stalled frame timeout then Esc");
      applyStimulus(8'h76, 1'b0, 1'b1, 6);
      ferr_dont_care = 1'b1;
      idle(50100);
      ferr_dont_care = 1'b0;
      m_ext = 1'b0;
      m_brk = 1'b0;
      checkOutput("t5 timeout error count", dc_ferr_cnt, 1);
      applyStimulus(8'h76, 1'b0, 1'b1, 11);
      idle(10);
      checkOutput("t5 reset_request count", rst_cnt, 1);

      $display("[TB] test 6: reset in the middle of a frame");
      applyStimulus(8'h3D, 1'b0, 1'b1, 6);
      reset = 1'b1;
      sched.delete();
      m_ext = 1'b0;   m_brk = 1'b0;   m_last = '0;
      idle(3);
      reset = 1'b0;
      idle(40);
      checkOutput("t6 no pulse after reset", sel_cnt, 3);
      applyStimulus(8'h3D, 1'b0, 1'b1, 11);
      idle(10);
      checkOutput("t6 select count", sel_cnt, 4);
      checkOutput("t6 cell", last_cell, 6);
      checkOutput("final stray error count", ferr_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
